bcd_serial_feeder: RTL and testbench

Upstream stage for the serial excess-3 converter. It accepts parallel BCD digits over a valid/ready handshake, buffers them in a small FIFO, and shifts each digit out LSB-first on the single-bit line `x` that the converter samples. It emits one contiguous 4-cycle frame per digit, with a frame marker on bit 0. Invalid codes (>9) are consumed, dropped and flagged.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_serial_feeder_if.sv | 25 ++
 rtl/digit_fifo.sv | 66 ++++++
 rtl/bcd_serial_feeder.sv | 102 ++++++++++
 tb/tb_bcd_serial_feeder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit check
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int BITCNT_W = 2;

    localparam logic [BCD_W-1:0]    BCD_MAX     = 4'd9;
    localparam logic [BITCNT_W-1:0] BITCNT_LAST = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when the code is a legal decimal digit
    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_feeder_if.sv
// rtl/bcd_serial_feeder_if.sv - digit handshake and serial output bundle
interface bcd_serial_feeder_if;
    import bcd_pkg::*;

    logic [BCD_W-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             frame;
    logic             busy;
    logic             err;

    // Producer/consumer side: drives digits, watches the serial line
    modport master (
        output din, din_valid,
        input  din_ready, x, frame, busy, err
    );

    // Feeder side
    modport slave (
        input  din, din_valid,
        output din_ready, x, frame, busy, err
    );

endinterface

// File: rtl/digit_fifo.sv
// rtl/digit_fifo.sv - small synchronous FIFO with count, full and empty
module digit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and count; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bcd_serial_feeder.sv
// rtl/bcd_serial_feeder.sv - buffers BCD digits and shifts them out LSB-first in 4-cycle frames
module bcd_serial_feeder
    import bcd_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_feeder_if.slave  bus
);

    logic                    transfer;
    logic                    digit_ok;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [BCD_W-1:0]        fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    state_t                  state_q;
    logic [BCD_W-1:0]        shreg_q;
    logic [BITCNT_W-1:0]     bitcnt_q;
    logic                    err_q;

    assign bus.din_ready = !rst && !fifo_full;
    assign transfer      = bus.din_valid && bus.din_ready;
    assign digit_ok      = is_bcd(bus.din);
    assign fifo_push     = transfer && digit_ok;

    digit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BCD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (bus.din),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pop whenever the FSM is ready to load a new digit and one is waiting
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == IDLE)
                fifo_pop = 1'b1;
            else if (bitcnt_q == BITCNT_LAST)
                fifo_pop = 1'b1;
        end
    end

    // Frame sequencer: load a digit, shift four bits, chain straight into the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg_q  <= fifo_rdata;
                        bitcnt_q <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bitcnt_q == BITCNT_LAST) begin
                        if (!fifo_empty) begin
                            shreg_q  <= fifo_rdata;
                            bitcnt_q <= '0;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end else begin
                        shreg_q  <= {1'b0, shreg_q[BCD_W-1:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One-cycle flag for a consumed out-of-range code
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= transfer && !digit_ok;
    end

    assign bus.x     = (state_q == SHIFT) ? shreg_q[0] : IDLE_BIT;
    assign bus.frame = (state_q == SHIFT) && (bitcnt_q == '0);
    assign bus.busy  = (state_q == SHIFT) || (fifo_count != '0);
    assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_serial_feeder.sv
// tb/tb_bcd_serial_feeder.sv - randomized and directed self-checking bench for bcd_serial_feeder
module tb_bcd_serial_feeder;
    import bcd_pkg::*;

    localparam int   DEPTH    = 2;
    localparam logic IDLE_BIT = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_serial_feeder_if bus();

    bcd_serial_feeder #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    // Timeline model: each accepted legal digit has an accept edge a and a pop edge p;
    // its bits occupy cycles p..p+3 on x.
    int q_a[$];
    int q_p[$];
    int q_d[$];
    int last_p;
    int err_edge;

    logic h_x [4096];
    logic h_f [4096];
    logic h_b [4096];
    logic h_r [4096];
    logic h_e [4096];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_p.delete();
        q_d.delete();
        last_p   = -100;
        err_edge = -100;
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic r, output logic acc);
        int   t;
        int   cnt;
        int   a;
        int   p;
        logic ex, ef, eb, er, ee;
        @(negedge clk);
        t = cyc;
        while (q_p.size() > 0 && q_p[0] + 3 < t) begin
            void'(q_a.pop_front());
            void'(q_p.pop_front());
            void'(q_d.pop_front());
        end
        ex = IDLE_BIT; ef = 1'b0; eb = 1'b0; cnt = 0;
        foreach (q_a[i]) begin
            if (q_p[i] <= t && t < q_p[i] + 4) begin
                ex = 1'((q_d[i] >> (t - q_p[i])) & 1);
                ef = (t == q_p[i]);
            end
            if (q_a[i] <= t) eb = 1'b1;
            if (q_a[i] <= t && q_p[i] > t) cnt++;
        end
        er = !rst && (cnt < DEPTH);
        ee = (err_edge == t);
        if (chk_on) begin
            chk("x", 32'(bus.x), 32'(ex));
            chk("frame", 32'(bus.frame), 32'(ef));
            chk("busy", 32'(bus.busy), 32'(eb));
            chk("din_ready", 32'(bus.din_ready), 32'(er));
            chk("err", 32'(bus.err), 32'(ee));
        end
        h_x[t & 4095] = bus.x;
        h_f[t & 4095] = bus.frame;
        h_b[t & 4095] = bus.busy;
        h_r[t & 4095] = bus.din_ready;
        h_e[t & 4095] = bus.err;

        rst           = r;
        bus.din_valid = v;
        bus.din       = d;
        acc = v && !r && (cnt < DEPTH);
        if (r) begin
            model_reset();
        end else if (acc) begin
            a = t + 1;
            if (d <= 4'd9) begin
                p = (a + 1 > last_p + 4) ? a + 1 : last_p + 4;
                q_a.push_back(a);
                q_p.push_back(p);
                q_d.push_back(int'(d));
                last_p = p;
            end else begin
                err_edge = a;
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 1'b0, acc);
    endtask

    task automatic offer(input logic [3:0] d, output int a);
        logic acc;
        a = -1;
        for (int k = 0; k < 50 && a < 0; k++) begin
            step(1'b1, d, 1'b0, acc);
            if (acc) a = cyc + 1;
        end
        if (a < 0) begin
            errors++;
            $display("FAIL offer_timeout digit %0d got no ready expected ready within 50 cycles", d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, a1, a2, a12, p6, ones, frames;
        logic acc, v, saw_low;
        logic [3:0]  d;
        logic [11:0] pat;
        logic [3:0]  five;

        model_reset();
        bus.din_valid = 1'b0;
        bus.din       = 4'd0;
        step(1'b0, 4'd0, 1'b1, acc);
        step(1'b0, 4'd0, 1'b1, acc);
        chk_on = 1'b1;
        step(1'b0, 4'd0, 1'b1, acc);
        step(1'b0, 4'd0, 1'b0, acc);
        chk("reset_busy", 32'(h_b[(cyc) & 4095]), 32'd0);
        chk("reset_ready", 32'(h_r[(cyc) & 4095]), 32'd0);
        idle(2);

        // Single digit 5
        offer(4'd5, a0);
        idle(8);
        five = 4'b0101;
        for (int k = 0; k < 4; k++)
            chk("lit_5_x", 32'(h_x[(a0 + 1 + k) & 4095]), 32'(five[k]));
        chk("lit_5_frame0", 32'(h_f[(a0 + 1) & 4095]), 32'd1);
        chk("lit_5_frame1", 32'(h_f[(a0 + 2) & 4095]), 32'd0);
        chk("lit_5_idle_x", 32'(h_x[(a0 + 5) & 4095]), 32'(IDLE_BIT));
        chk("lit_5_idle_busy", 32'(h_b[(a0 + 5) & 4095]), 32'd0);

        // Stream 0,9,3 held valid, back to back
        offer(4'd0, a0);
        offer(4'd9, a1);
        offer(4'd3, a2);
        idle(16);
        pat = {4'b0011, 4'b1001, 4'b0000};
        for (int k = 0; k < 12; k++)
            chk("lit_stream_x", 32'(h_x[(a0 + 1 + k) & 4095]), 32'(pat[k]));
        saw_low = 1'b0;
        for (int k = a0; k < a0 + 8; k++)
            if (h_r[k & 4095] === 1'b0) saw_low = 1'b1;
        chk("lit_stream_ready_drop", 32'(saw_low), 32'd1);

        // 2, 12, 7: one err pulse, two frames
        offer(4'd2, a0);
        offer(4'd12, a12);
        offer(4'd7, a1);
        idle(16);
        chk("lit_err_pulse", 32'(h_e[a12 & 4095]), 32'd1);
        chk("lit_err_after", 32'(h_e[(a12 + 1) & 4095]), 32'd0);
        chk("lit_err_before", 32'(h_e[(a12 - 1) & 4095]), 32'd0);
        frames = 0;
        for (int k = a0; k < a0 + 20; k++)
            if (h_f[k & 4095] === 1'b1) frames++;
        chk("lit_err_frames", 32'(frames), 32'd2);

        // Fill while shifting
        offer(4'd1, a0);
        offer(4'd2, a0);
        offer(4'd4, a0);
        offer(4'd8, a0);
        idle(20);

        // Reset during bit 2 of digit 6 with one digit buffered
        offer(4'd6, a0);
        p6 = last_p;
        offer(4'd1, a1);
        while (cyc + 1 < p6 + 2) step(1'b0, 4'd0, 1'b0, acc);
        step(1'b0, 4'd0, 1'b1, acc);
        chk("lit_rst_bit2", 32'(h_x[(p6 + 2) & 4095]), 32'd1);
        step(1'b0, 4'd0, 1'b1, acc);
        chk("lit_rst_x", 32'(h_x[(p6 + 3) & 4095]), 32'(IDLE_BIT));
        chk("lit_rst_frame", 32'(h_f[(p6 + 3) & 4095]), 32'd0);
        chk("lit_rst_busy", 32'(h_b[(p6 + 3) & 4095]), 32'd0);
        chk("lit_rst_ready", 32'(h_r[(p6 + 3) & 4095]), 32'd0);
        idle(12);
        ones = 0;
        for (int k = p6 + 3; k < p6 + 15; k++)
            if (h_x[k & 4095] !== IDLE_BIT) ones++;
        chk("lit_rst_no_residual", 32'(ones), 32'd0);

        // Randomized traffic with hold-while-not-ready and occasional reset
        v = 1'b0;
        d = 4'd0;
        acc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            if (!v || acc) begin
                v = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 90 : 40));
                d = ($urandom_range(0, 99) < 15) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
            end
            r = ($urandom_range(0, 299) == 0);
            step(v, d, r, acc);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
